color_stats: RTL and testbench

Parametrised per-channel frame statistics block for the ISP pipeline. It sits after denoise and before white balance. It passes the pixel stream through with one cycle of latency. It also accumulates a per-channel sum and pixel count over each frame and, at frame end, computes true means with a shared sequential divider. The divider works for any frame size, not only power-of-two squares.

---
 rtl/isp_stat_pkg.sv | 18 +
 rtl/seq_divider.sv | 62 ++++++
 rtl/color_stats.sv | 250 +++++++++++++++++++++++++
 tb/tb_color_stats.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isp_stat_pkg.sv
// Shared definitions for the ISP statistics blocks: colour codes, default
// pixel width and the frame-statistics FSM state encoding.
package isp_stat_pkg;

    localparam logic [1:0] RED   = 2'd0;
    localparam logic [1:0] GREEN = 2'd1;
    localparam logic [1:0] BLUE  = 2'd2;

    localparam int unsigned DEFAULT_DW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } stat_state_e;

endpackage

// File: rtl/seq_divider.sv
// Restoring sequential divider. i_start loads a new operand pair; the
// quotient is produced N_W cycles later. o_done is high during the final
// step cycle and o_quo shows the quotient that step completes, so callers
// can capture it on the same edge. A zero divisor yields a zero quotient.
module seq_divider #(
    parameter int unsigned N_W = 28,
    parameter int unsigned D_W = 20
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_start,
    input  logic [N_W-1:0] i_num,
    input  logic [D_W-1:0] i_den,
    output logic           o_done,
    output logic [N_W-1:0] o_quo
);

    localparam int unsigned C_W = $clog2(N_W + 1);

    logic [D_W-1:0] r_rem;
    logic [N_W-1:0] r_quo;
    logic [D_W-1:0] r_den;
    logic [C_W-1:0] r_cnt;

    logic [D_W:0]   w_shift;
    logic [D_W:0]   w_diff;
    logic           w_ge;
    logic [D_W-1:0] w_rem_nxt;
    logic [N_W-1:0] w_quo_nxt;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        w_shift   = {r_rem, r_quo[N_W-1]};
        w_diff    = w_shift - {1'b0, r_den};
        w_ge      = (w_shift >= {1'b0, r_den});
        w_rem_nxt = w_ge ? w_diff[D_W-1:0] : w_shift[D_W-1:0];
        w_quo_nxt = {r_quo[N_W-2:0], w_ge};
    end

    assign o_done = (r_cnt == C_W'(1));
    assign o_quo  = (r_den == '0) ? '0 : w_quo_nxt;

    // Operand load on start, otherwise step while the counter is non-zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= '0;
            r_quo <= '0;
            r_den <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_rem <= '0;
            r_quo <= i_num;
            r_den <= i_den;
            r_cnt <= C_W'(N_W);
        end else if (r_cnt != '0) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt - C_W'(1);
        end
    end

endmodule

// File: rtl/color_stats.sv
// Per-channel frame statistics with one-cycle pixel pass-through. Sums and
// counts are snapshotted at frame end and divided channel by channel on a
// single shared divider. Define COLOR_STATS_MAX_EN to also track per-channel
// frame maxima on max_o; otherwise max_o is tied to zero.
module color_stats
    import isp_stat_pkg::*;
#(
    parameter int unsigned DW     = DEFAULT_DW,
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned CNT_W  = 20,
    parameter int unsigned SUM_W  = CNT_W + DW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_i,
    input  logic [1:0]           color_i,
    input  logic [DW-1:0]        value_i,
    input  logic                 last_i,
    output logic                 valid_o,
    output logic [1:0]           color_o,
    output logic [DW-1:0]        value_o,
    output logic                 last_o,
    output logic [NUM_CH*DW-1:0] mean_o,
    output logic                 mean_valid_o,
    output logic                 busy_o,
    output logic                 ovf_o,
    output logic                 overrun_o,
    output logic [NUM_CH*DW-1:0] max_o
);

    localparam int unsigned CH_W = 2;

    logic              r_valid, r_last;
    logic [1:0]        r_color;
    logic [DW-1:0]     r_value;

    logic [SUM_W-1:0]  r_sum      [NUM_CH];
    logic [CNT_W-1:0]  r_cnt      [NUM_CH];
    logic [SUM_W-1:0]  r_sum_snap [NUM_CH];
    logic [CNT_W-1:0]  r_cnt_snap [NUM_CH];
    logic [DW-1:0]     r_stage    [NUM_CH];
    logic              r_ovf, r_ovf_snap, r_ovf_o;

    stat_state_e       r_state;
    logic [CH_W-1:0]   r_ch;
    logic [NUM_CH*DW-1:0] r_mean;
    logic              r_mean_valid, r_overrun;

    logic [SUM_W-1:0]  w_sum_nxt [NUM_CH];
    logic [CNT_W-1:0]  w_cnt_nxt [NUM_CH];
    logic              w_ovf_nxt;
    logic              w_frame_end, w_accept, w_last_ch, w_enter_done;
    logic [SUM_W-1:0]  w_div_num;
    logic [CNT_W-1:0]  w_div_den;
    logic              w_div_done;
    logic [SUM_W-1:0]  w_div_quo;
    logic [NUM_CH*DW-1:0] w_mean_nxt;
    logic              w_unused;

    assign valid_o      = r_valid;
    assign color_o      = r_color;
    assign value_o      = r_value;
    assign last_o       = r_last;
    assign mean_o       = r_mean;
    assign mean_valid_o = r_mean_valid;
    assign ovf_o        = r_ovf_o;
    assign overrun_o    = r_overrun;
    assign busy_o       = (r_state != IDLE);

    assign w_frame_end  = r_valid && r_last;
    assign w_accept     = w_frame_end && (r_state == IDLE);
    assign w_last_ch    = (r_ch == CH_W'(NUM_CH - 1));
    assign w_enter_done = (r_state == DIV) && w_div_done && w_last_ch;
    // Quotient never exceeds 2^DW-1, so only the low bits carry the mean.
    assign w_unused     = ^w_div_quo[SUM_W-1:DW];

    // Unconditional input register stage feeding pass-through and accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_color <= '0;
            r_value <= '0;
            r_last  <= 1'b0;
        end else begin
            r_valid <= valid_i;
            r_color <= color_i;
            r_value <= value_i;
            r_last  <= last_i;
        end
    end

    // Next accumulator values including the current sample; saturated channels hold.
    always_comb begin
        w_ovf_nxt = r_ovf;
        for (int c = 0; c < NUM_CH; c++) begin
            w_sum_nxt[c] = r_sum[c];
            w_cnt_nxt[c] = r_cnt[c];
            if (r_valid && (r_color == CH_W'(c))) begin
                if (&r_cnt[c]) begin
                    w_ovf_nxt = 1'b1;
                end else begin
                    w_sum_nxt[c] = r_sum[c] + SUM_W'(r_value);
                    w_cnt_nxt[c] = r_cnt[c] + CNT_W'(1);
                end
            end
        end
    end

    // Live accumulators clear at frame end; snapshot only when the divider is free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_sum[c]      <= '0;
                r_cnt[c]      <= '0;
                r_sum_snap[c] <= '0;
                r_cnt_snap[c] <= '0;
            end
            r_ovf      <= 1'b0;
            r_ovf_snap <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_sum[c] <= w_frame_end ? '0 : w_sum_nxt[c];
                r_cnt[c] <= w_frame_end ? '0 : w_cnt_nxt[c];
                if (w_accept) begin
                    r_sum_snap[c] <= w_sum_nxt[c];
                    r_cnt_snap[c] <= w_cnt_nxt[c];
                end
            end
            r_ovf <= w_frame_end ? 1'b0 : w_ovf_nxt;
            if (w_accept) begin
                r_ovf_snap <= w_ovf_nxt;
            end
        end
    end

    // Divider operand mux and mean vector with the finishing channel merged in.
    always_comb begin
        w_div_num  = '0;
        w_div_den  = '0;
        w_mean_nxt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_ch == CH_W'(c)) begin
                w_div_num = r_sum_snap[c];
                w_div_den = r_cnt_snap[c];
                w_mean_nxt[c*DW +: DW] = w_div_quo[DW-1:0];
            end else begin
                w_mean_nxt[c*DW +: DW] = r_stage[c];
            end
        end
    end

    seq_divider #(
        .N_W (SUM_W),
        .D_W (CNT_W)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (r_state == LOAD),
        .i_num   (w_div_num),
        .i_den   (w_div_den),
        .o_done  (w_div_done),
        .o_quo   (w_div_quo)
    );

    // Sequencer: walk the channels through the divider, then publish results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ch         <= '0;
            r_mean       <= '0;
            r_mean_valid <= 1'b0;
            r_overrun    <= 1'b0;
            r_ovf_o      <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_stage[c] <= '0;
            end
        end else begin
            r_mean_valid <= 1'b0;
            r_overrun    <= w_frame_end && (r_state != IDLE);
            unique case (r_state)
                IDLE: begin
                    if (w_frame_end) begin
                        r_state <= LOAD;
                        r_ch    <= '0;
                    end
                end
                LOAD: r_state <= DIV;
                DIV: begin
                    if (w_div_done) begin
                        r_stage[r_ch] <= w_div_quo[DW-1:0];
                        if (w_last_ch) begin
                            r_state      <= DONE;
                            r_mean       <= w_mean_nxt;
                            r_mean_valid <= 1'b1;
                            r_ovf_o      <= r_ovf_snap;
                        end else begin
                            r_ch    <= r_ch + CH_W'(1);
                            r_state <= LOAD;
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef COLOR_STATS_MAX_EN
    logic [DW-1:0]        r_max      [NUM_CH];
    logic [DW-1:0]        r_max_snap [NUM_CH];
    logic [DW-1:0]        w_max_nxt  [NUM_CH];
    logic [NUM_CH*DW-1:0] r_max_o;

    // Running maximum including the current sample.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_max_nxt[c] = r_max[c];
            if (r_valid && (r_color == CH_W'(c)) && (r_value > r_max[c])) begin
                w_max_nxt[c] = r_value;
            end
        end
    end

    // Maxima follow the same clear/snapshot/publish timing as the sums.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_max[c]      <= '0;
                r_max_snap[c] <= '0;
            end
            r_max_o <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_max[c] <= w_frame_end ? '0 : w_max_nxt[c];
                if (w_accept) begin
                    r_max_snap[c] <= w_max_nxt[c];
                end
                if (w_enter_done) begin
                    r_max_o[c*DW +: DW] <= r_max_snap[c];
                end
            end
        end
    end

    assign max_o = r_max_o;
`else
    assign max_o = '0;
`endif

endmodule

// File: tb/tb_color_stats.sv
// Scoreboard bench for color_stats: a default instance for the main tests and
// a CNT_W=4 instance for count saturation. Expected pass-through samples,
// frame means and overrun pulses are queued by the driver and popped by a
// negedge monitor.
module tb_color_stats;
    import isp_stat_pkg::*;

    typedef struct {
        int unsigned cyc;
        logic [1:0]  c;
        logic [7:0]  v;
        logic        l;
    } pt_t;

    typedef struct {
        int unsigned cyc;
        logic [23:0] mean;
        logic [23:0] mx;
        logic        ovf;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       valid_i, last_i, sat_sel;
    logic [1:0] color_i;
    logic [7:0] value_i;

    logic        valid_o, last_o, mean_valid_o, busy_o, ovf_o, overrun_o;
    logic [1:0]  color_o;
    logic [7:0]  value_o;
    logic [23:0] mean_o, max_o;

    logic        s_valid_o, s_last_o, s_mean_valid_o, s_busy_o, s_ovf_o, s_overrun_o;
    logic [1:0]  s_color_o;
    logic [7:0]  s_value_o;
    logic [23:0] s_mean_o, s_max_o;

    color_stats u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_i      (valid_i & ~sat_sel),
        .color_i      (color_i),
        .value_i      (value_i),
        .last_i       (last_i),
        .valid_o      (valid_o),
        .color_o      (color_o),
        .value_o      (value_o),
        .last_o       (last_o),
        .mean_o       (mean_o),
        .mean_valid_o (mean_valid_o),
        .busy_o       (busy_o),
        .ovf_o        (ovf_o),
        .overrun_o    (overrun_o),
        .max_o        (max_o)
    );

    color_stats #(
        .CNT_W (4)
    ) u_dut_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_i      (valid_i & sat_sel),
        .color_i      (color_i),
        .value_i      (value_i),
        .last_i       (last_i),
        .valid_o      (s_valid_o),
        .color_o      (s_color_o),
        .value_o      (s_value_o),
        .last_o       (s_last_o),
        .mean_o       (s_mean_o),
        .mean_valid_o (s_mean_valid_o),
        .busy_o       (s_busy_o),
        .ovf_o        (s_ovf_o),
        .overrun_o    (s_overrun_o),
        .max_o        (s_max_o)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int mv_count = 0;

    pt_t         pt_q[$];
    res_t        mean_q[$];
    res_t        sat_q[$];
    int unsigned ovr_q[$];

    longint unsigned m_sum[3];
    int unsigned     m_cnt[3];
    logic [7:0]      m_max[3];
    logic            m_ovf;
    int unsigned     busy_until;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < 3; c++) begin
            m_sum[c] = 0;
            m_cnt[c] = 0;
            m_max[c] = 8'd0;
        end
        m_ovf = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        last_i  = 1'b0;
        color_i = 2'd0;
        value_i = 8'd0;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) idle();
    endtask

    task automatic drive(input logic [1:0] c, input logic [7:0] v, input logic l);
        res_t        r;
        int unsigned n;
        int unsigned cmax;
        @(posedge clk);
        #1;
        valid_i = 1'b1;
        color_i = c;
        value_i = v;
        last_i  = l;
        n    = cyc;
        cmax = sat_sel ? 32'd15 : 32'hFFFFF;
        if (!sat_sel) pt_q.push_back(pt_t'{n + 1, c, v, l});
        if (c < 2'd3) begin
            if (m_cnt[c] == cmax) begin
                m_ovf = 1'b1;
            end else begin
                m_sum[c] += v;
                m_cnt[c]++;
            end
            if (v > m_max[c]) m_max[c] = v;
        end
        if (l) begin
            if (!sat_sel && (n + 1 <= busy_until)) begin
                ovr_q.push_back(n + 2);
            end else begin
                r.cyc  = n + (sat_sel ? 41 : 89);
                r.mean = '0;
                r.mx   = '0;
                for (int k = 0; k < 3; k++) begin
                    r.mean[k*8 +: 8] = (m_cnt[k] != 0) ? 8'(m_sum[k] / m_cnt[k]) : 8'd0;
`ifdef COLOR_STATS_MAX_EN
                    r.mx[k*8 +: 8] = m_max[k];
`endif
                end
                r.ovf = m_ovf;
                if (sat_sel) begin
                    sat_q.push_back(r);
                end else begin
                    busy_until = r.cyc;
                    mean_q.push_back(r);
                end
            end
            model_clear();
        end
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while ((mean_q.size() != 0 || sat_q.size() != 0) && k < budget) begin
            idle();
            k++;
        end
        check("drain", 64'(mean_q.size() + sat_q.size()), 64'd0);
        idle_n(3);
    endtask

    // Scoreboard consumer: pass-through, frame results and overrun pulses.
    always @(negedge clk) begin
        pt_t         p;
        res_t        e;
        int unsigned oc;
        if (rst_n) begin
            if (valid_o) begin
                if (pt_q.size() == 0) begin
                    check("pt_unexpected", 64'd1, 64'd0);
                end else begin
                    p = pt_q.pop_front();
                    check("pt_cycle", 64'(cyc), 64'(p.cyc));
                    check("pt_data", {53'd0, color_o, value_o, last_o}, {53'd0, p.c, p.v, p.l});
                end
            end
            if (mean_valid_o) begin
                mv_count++;
                if (mean_q.size() == 0) begin
                    check("mean_unexpected", 64'd1, 64'd0);
                end else begin
                    e = mean_q.pop_front();
                    check("mean_cycle", 64'(cyc), 64'(e.cyc));
                    check("mean", 64'(mean_o), 64'(e.mean));
                    check("max", 64'(max_o), 64'(e.mx));
                    check("ovf", 64'(ovf_o), 64'(e.ovf));
                    check("busy_in_done", 64'(busy_o), 64'd1);
                end
            end
            if (overrun_o) begin
                if (ovr_q.size() == 0) begin
                    check("overrun_unexpected", 64'd1, 64'd0);
                end else begin
                    oc = ovr_q.pop_front();
                    check("overrun_cycle", 64'(cyc), 64'(oc));
                end
            end
            if (s_mean_valid_o) begin
                if (sat_q.size() == 0) begin
                    check("sat_unexpected", 64'd1, 64'd0);
                end else begin
                    e = sat_q.pop_front();
                    check("sat_cycle", 64'(cyc), 64'(e.cyc));
                    check("sat_mean", 64'(s_mean_o), 64'(e.mean));
                    check("sat_max", 64'(s_max_o), 64'(e.mx));
                    check("sat_ovf", 64'(s_ovf_o), 64'(e.ovf));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n = 1'b0;
        valid_i = 1'b0;
        last_i = 1'b0;
        color_i = 2'd0;
        value_i = 8'd0;
        sat_sel = 1'b0;
        busy_until = 0;
        model_clear();

        @(negedge clk);
        check("reset_outputs", {valid_o, color_o, value_o, last_o, mean_o, mean_valid_o,
                                busy_o, ovf_o, overrun_o, max_o}, 64'd0);
        check("reset_sat_outputs", {s_valid_o, s_color_o, s_value_o, s_last_o, s_mean_o,
                                    s_mean_valid_o, s_busy_o, s_ovf_o, s_overrun_o, s_max_o},
              64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle_n(2);

        // 4x4 mosaic, R/G/B constant per channel.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (r % 2 == 0) drive((c % 2 == 0) ? RED : GREEN, (c % 2 == 0) ? 8'd100 : 8'd50,
                                      1'b0);
                else            drive((c % 2 == 0) ? GREEN : BLUE, (c % 2 == 0) ? 8'd50 : 8'd200,
                                      (r == 3) && (c == 3));
            end
        end
        wait_drain(150);

        // Non-power-of-two count on red only.
        drive(RED, 8'd10, 1'b0);
        drive(RED, 8'd11, 1'b0);
        drive(RED, 8'd13, 1'b1);
        wait_drain(150);

        // Out-of-range colour interleaved; passed through, excluded from stats.
        drive(RED, 8'd20, 1'b0);
        drive(2'd3, 8'd250, 1'b0);
        drive(GREEN, 8'd30, 1'b0);
        drive(2'd3, 8'd7, 1'b0);
        drive(BLUE, 8'd40, 1'b1);
        wait_drain(150);

        // Back-to-back frames: second frame end lands while busy.
        drive(RED, 8'd60, 1'b0);
        drive(RED, 8'd61, 1'b0);
        drive(GREEN, 8'd70, 1'b0);
        drive(BLUE, 8'd80, 1'b1);
        idle_n(18);
        drive(RED, 8'd5, 1'b0);
        drive(GREEN, 8'd6, 1'b1);
        idle_n(100);
        drive(RED, 8'd1, 1'b0);
        drive(GREEN, 8'd2, 1'b0);
        drive(BLUE, 8'd3, 1'b0);
        drive(BLUE, 8'd4, 1'b1);
        wait_drain(150);
        check("overrun_drained", 64'(ovr_q.size()), 64'd0);

        // Count saturation on the narrow-count instance.
        sat_sel = 1'b1;
        for (int i = 0; i < 20; i++) drive(RED, 8'd255, i == 19);
        wait_drain(80);
        sat_sel = 1'b0;
        idle_n(2);

        // Reset in the middle of a division.
        drive(GREEN, 8'd77, 1'b1);
        idle_n(40);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("reset_mid_div", {valid_o, color_o, value_o, last_o, mean_o, mean_valid_o,
                                busy_o, ovf_o, overrun_o, max_o}, 64'd0);
        mean_q.delete();
        pt_q.delete();
        ovr_q.delete();
        model_clear();
        busy_until = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        base = mv_count;
        idle_n(100);
        check("no_mean_valid_after_reset", 64'(mv_count - base), 64'd0);

        drive(BLUE, 8'd9, 1'b0);
        drive(BLUE, 8'd10, 1'b1);
        wait_drain(150);

        check("pt_drained", 64'(pt_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
